// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with pending-write scoreboard,
//               RAW/WAW stall and same-cycle writeback bypass.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 16,
    parameter int PC_REG    = 15,
    parameter int PC_OFFSET = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [3:0]        id_rs1,
    input  logic              id_rs1_used,
    input  logic [3:0]        id_rs2,
    input  logic              id_rs2_used,
    input  logic [3:0]        id_rd,
    input  logic              id_rd_we,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic              wb_valid,
    input  logic [3:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [3:0]        ex_rd,
    output logic              ex_rd_we,
    output logic [DATA_W-1:0] ex_pc,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [15:0]       busy
);

    localparam logic [3:0]        c_PC_IDX = 4'(PC_REG);
    localparam logic [DATA_W-1:0] c_PC_OFF = DATA_W'(PC_OFFSET);

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_op1_q, ex_op1_d;
    logic [DATA_W-1:0] ex_op2_q, ex_op2_d;
    logic [3:0]        ex_rd_q, ex_rd_d;
    logic              ex_rd_we_q, ex_rd_we_d;
    logic [DATA_W-1:0] ex_pc_q, ex_pc_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [15:0]       busy_q, busy_d;

    logic w_byp1, w_byp2, w_byprd;
    logic w_haz1, w_haz2, w_waw, w_hazard;
    logic w_fire;
    logic [DATA_W-1:0] w_op1, w_op2;

    // The register file commits on the edge, so a same-cycle writeback both
    // supplies the operand and resolves the hazard on that register.
    assign w_byp1  = wb_valid && (wb_rd == id_rs1);
    assign w_byp2  = wb_valid && (wb_rd == id_rs2);
    assign w_byprd = wb_valid && (wb_rd == id_rd);

    assign w_haz1   = id_rs1_used && (id_rs1 != c_PC_IDX) && busy_q[id_rs1] && !w_byp1;
    assign w_haz2   = id_rs2_used && (id_rs2 != c_PC_IDX) && busy_q[id_rs2] && !w_byp2;
    assign w_waw    = id_rd_we && (id_rd != c_PC_IDX) && busy_q[id_rd] && !w_byprd;
    assign w_hazard = w_haz1 || w_haz2 || w_waw;

    assign id_ready = !w_hazard && !flush && (!ex_valid_q || ex_ready);
    assign w_fire   = id_valid && id_ready;

    assign w_op1 = (id_rs1 == c_PC_IDX) ? (id_pc + c_PC_OFF) :
                   w_byp1               ? wb_data : rf_rd1;
    assign w_op2 = (id_rs2 == c_PC_IDX) ? (id_pc + c_PC_OFF) :
                   w_byp2               ? wb_data : rf_rd2;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        ex_rd_d    = ex_rd_q;
        ex_rd_we_d = ex_rd_we_q;
        ex_pc_d    = ex_pc_q;
        ex_ctrl_d  = ex_ctrl_q;
        if (w_fire) begin
            ex_valid_d = 1'b1;
            ex_op1_d   = w_op1;
            ex_op2_d   = w_op2;
            ex_rd_d    = id_rd;
            ex_rd_we_d = id_rd_we;
            ex_pc_d    = id_pc;
            ex_ctrl_d  = id_ctrl;
        end else if (flush || ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // Clears first, then the issue set, so a set beats a same-index clear.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid && (wb_rd != c_PC_IDX))
            busy_d[wb_rd] = 1'b0;
        if (flush && ex_valid_q && ex_rd_we_q && (ex_rd_q != c_PC_IDX))
            busy_d[ex_rd_q] = 1'b0;
        if (w_fire && id_rd_we && (id_rd != c_PC_IDX))
            busy_d[id_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_rd_q    <= '0;
            ex_rd_we_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_ctrl_q  <= '0;
            busy_q     <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_rd_q    <= ex_rd_d;
            ex_rd_we_q <= ex_rd_we_d;
            ex_pc_q    <= ex_pc_d;
            ex_ctrl_q  <= ex_ctrl_d;
            busy_q     <= busy_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_op1   = ex_op1_q;
    assign ex_op2   = ex_op2_q;
    assign ex_rd    = ex_rd_q;
    assign ex_rd_we = ex_rd_we_q;
    assign ex_pc    = ex_pc_q;
    assign ex_ctrl  = ex_ctrl_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : directed self-checking bench for id_ex_stage.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [3:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_rd_we;
    logic [31:0] id_pc;
    logic [15:0] id_ctrl;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid, ex_ready, ex_rd_we;
    logic [31:0] ex_op1, ex_op2, ex_pc;
    logic [3:0]  ex_rd;
    logic [15:0] ex_ctrl;
    logic [15:0] busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .CTRL_W(16), .PC_REG(15), .PC_OFFSET(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_pc(id_pc), .id_ctrl(id_ctrl),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_pc(ex_pc), .ex_ctrl(ex_ctrl),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] rs1, input logic u1, input logic [3:0] rs2,
                             input logic u2, input logic [3:0] rd, input logic we);
        id_valid    = 1'b1;
        id_rs1      = rs1;  id_rs1_used = u1;
        id_rs2      = rs2;  id_rs2_used = u2;
        id_rd       = rd;   id_rd_we    = we;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_rd_we = 0; id_pc = 0; id_ctrl = 0;
        rf_rd1 = 0; rf_rd2 = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
        flush = 0; ex_ready = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Load EX with a register write, then reset asynchronously mid-cycle
        set_instr(4'd1, 1, 4'd2, 1, 4'd5, 1);
        rf_rd1 = 32'd11; id_pc = 32'h40; id_ctrl = 16'hA5A5; ex_ready = 0;
        #1 check("pre_ready", id_ready, 1);
        step();
        id_valid = 0;
        check("pre_ex_valid", ex_valid, 1);
        check("pre_busy", busy, 16'h0020);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_op1", ex_op1, 0);
        check("rst_ex_op2", ex_op2, 0);
        check("rst_ex_rd", ex_rd, 0);
        check("rst_ex_rd_we", ex_rd_we, 0);
        check("rst_ex_pc", ex_pc, 0);
        check("rst_ex_ctrl", ex_ctrl, 0);
        check("rst_busy", busy, 0);
        check("rst_id_ready", id_ready, 1);
        flush = 1;
        #1 check("rst_flush_ready", id_ready, 0);
        flush = 0;
        step();
        rst_n = 1'b1;

        // Basic issue r3 = r1 + r2
        set_instr(4'd1, 1, 4'd2, 1, 4'd3, 1);
        rf_rd1 = 32'd5; rf_rd2 = 32'd7; id_pc = 32'h200; id_ctrl = 16'h1234; ex_ready = 1;
        #1 check("issue_ready", id_ready, 1);
        step();
        check("issue_valid", ex_valid, 1);
        check("issue_op1", ex_op1, 5);
        check("issue_op2", ex_op2, 7);
        check("issue_rd", ex_rd, 3);
        check("issue_rd_we", ex_rd_we, 1);
        check("issue_pc", ex_pc, 32'h200);
        check("issue_ctrl", ex_ctrl, 16'h1234);
        check("issue_busy", busy, 16'h0008);

        // RAW on r3, resolved by same-cycle writeback bypass
        set_instr(4'd3, 1, 4'd4, 1, 4'd6, 1);
        rf_rd1 = 32'd99; rf_rd2 = 32'd8;
        #1 check("raw_stall", id_ready, 0);
        step();
        check("raw_drain", ex_valid, 0);
        check("raw_busy_held", busy, 16'h0008);
        wb_valid = 1; wb_rd = 4'd3; wb_data = 32'd42;
        #1 check("raw_bypass_ready", id_ready, 1);
        step();
        wb_valid = 0;
        check("raw_op1_bypass", ex_op1, 42);
        check("raw_op2", ex_op2, 8);
        check("raw_busy", busy, 16'h0040);

        // Back-pressure holds EX payload
        ex_ready = 0;
        set_instr(4'd1, 1, 4'd2, 1, 4'd7, 1);
        rf_rd1 = 32'h11; rf_rd2 = 32'h22;
        #1 check("bp_stall", id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid", ex_valid, 1);
            check("bp_hold_op1", ex_op1, 42);
            check("bp_hold_rd", ex_rd, 6);
        end
        ex_ready = 1;
        #1 check("bp_release_ready", id_ready, 1);
        step();
        check("bp_load_rd", ex_rd, 7);
        check("bp_load_op1", ex_op1, 32'h11);
        check("bp_busy", busy, 16'h00C0);

        // WAW on r6, then busy registers named by unused sources
        set_instr(4'd0, 0, 4'd0, 0, 4'd6, 1);
        #1 check("waw_stall", id_ready, 0);
        set_instr(4'd7, 0, 4'd6, 0, 4'd9, 1);
        #1 check("unused_src_ready", id_ready, 1);
        step();
        ex_ready = 0;
        check("unused_rd", ex_rd, 9);
        check("unused_busy", busy, 16'h02C0);

        // Flush kills EX write to r9 and blocks issue
        set_instr(4'd1, 1, 4'd2, 1, 4'd10, 1);
        flush = 1;
        #1 check("flush_ready", id_ready, 0);
        step();
        flush = 0;
        check("flush_valid", ex_valid, 0);
        check("flush_busy", busy, 16'h00C0);

        // PC alias as operand; rd=PC never scoreboarded; wb to PC ignored
        ex_ready = 1;
        set_instr(4'd15, 1, 4'd2, 1, 4'd15, 1);
        id_pc = 32'h100; rf_rd2 = 32'd3;
        wb_valid = 1; wb_rd = 4'd15; wb_data = 32'hDEAD;
        #1 check("pc_ready", id_ready, 1);
        step();
        wb_valid = 0;
        check("pc_op1", ex_op1, 32'h108);
        check("pc_op2", ex_op2, 3);
        check("pc_busy", busy, 16'h00C0);

        // Wrap of PC offset, and issue-set beating a same-cycle clear of r6
        set_instr(4'd15, 1, 4'd0, 0, 4'd6, 1);
        id_pc = 32'hFFFF_FFFC;
        wb_valid = 1; wb_rd = 4'd6; wb_data = 32'h77;
        #1 check("setwin_ready", id_ready, 1);
        step();
        wb_valid = 0; id_valid = 0;
        check("wrap_op1", ex_op1, 32'h4);
        check("setwin_busy", busy, 16'h00C0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
